// File: rtl/pipelined_memory_pkg.sv
// pipelined_memory_pkg: shared sizing helpers for the pipelined memory model and its response FIFO
package pipelined_memory_pkg;
  function automatic int min1_clog2(input int v);
    return v > 1 ? $clog2(v) : 1;
  endfunction
  function automatic int byte_offset_bits(input int line_size);
    return $clog2(line_size / 8);
  endfunction
  function automatic int index_bits(input int entries);
    return min1_clog2(entries);
  endfunction
endpackage

// File: rtl/pipelined_memory_if.sv
// pipelined_memory_if: valid/ready request and response channels between cache and memory
interface pipelined_memory_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int LINE_SIZE     = 32
);
  logic                     req_valid;
  logic                     req_ready;
  logic [ADDRESS_WIDTH-1:0] req_address;
  logic [LINE_SIZE-1:0]     req_data_in;
  logic                     req_wen;
  logic [LINE_SIZE/8-1:0]   req_strobe;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [LINE_SIZE-1:0]     resp_data_out;
  logic                     resp_is_write;
  logic                     resp_error;
  modport master (
    output req_valid, req_address, req_data_in, req_wen, req_strobe, resp_ready,
    input  req_ready, resp_valid, resp_data_out, resp_is_write, resp_error
  );
  modport slave (
    input  req_valid, req_address, req_data_in, req_wen, req_strobe, resp_ready,
    output req_ready, resp_valid, resp_data_out, resp_is_write, resp_error
  );
endinterface

// File: rtl/pipelined_memory_resp_fifo.sv
// resp_fifo: in-order response queue with wrapping pointers and simultaneous push/pop
module resp_fifo import pipelined_memory_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] dout_o
);
  localparam int PW = min1_clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign dout_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= din_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= nxt(wr_q);
      if (do_pop) rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
    end
endmodule

// File: rtl/pipelined_memory.sv
// pipelined_memory: fixed-latency, credit-limited main-memory model with byte strobes and range errors
module pipelined_memory import pipelined_memory_pkg::*; #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int LINE_SIZE       = 32,
  parameter int ENTRIES         = 1024,
  parameter int LATENCY         = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic               clk,
  input logic               rst_n,
  pipelined_memory_if.slave mem_if
);
  localparam int NB  = LINE_SIZE / 8;
  localparam int BOB = byte_offset_bits(LINE_SIZE);
  localparam int IW  = index_bits(ENTRIES);
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
  typedef struct packed {
    logic [LINE_SIZE-1:0] data;
    logic                 is_write;
    logic                 error;
  } resp_t;
  logic [LINE_SIZE-1:0]     mem_q [ENTRIES];
  logic [ADDRESS_WIDTH-1:0] word_idx;
  logic [IW-1:0]            idx;
  logic                     in_range, accept, pop, fifo_full, fifo_empty;
  logic [CW-1:0]            outstanding_q, outstanding_d;
  logic [LATENCY-1:0]       vld_q;
  resp_t                    pipe_q [LATENCY];
  resp_t                    stage_d, head;
  logic [$bits(resp_t)-1:0] fifo_dout;
  always_comb begin
    word_idx      = mem_if.req_address >> BOB;
    in_range      = word_idx < ADDRESS_WIDTH'(ENTRIES);
    idx           = word_idx[IW-1:0];
    accept        = mem_if.req_valid && mem_if.req_ready;
    pop           = mem_if.resp_valid && mem_if.resp_ready;
    outstanding_d = outstanding_q + CW'(accept) - CW'(pop);
    stage_d       = '{data: (mem_if.req_wen || !in_range) ? '0 : mem_q[idx],
                      is_write: mem_if.req_wen, error: !in_range};
    head          = fifo_empty ? '0 : resp_t'(fifo_dout);
  end
  assign mem_if.req_ready     = outstanding_q < CW'(MAX_OUTSTANDING);
  assign mem_if.resp_valid    = !fifo_empty;
  assign mem_if.resp_data_out = head.data;
  assign mem_if.resp_is_write = head.is_write;
  assign mem_if.resp_error    = head.error;
  // Array is deliberately outside the reset domain so accepted writes survive a reset.
  always_ff @(posedge clk)
    if (accept && in_range && mem_if.req_wen)
      for (int b = 0; b < NB; b++)
        if (mem_if.req_strobe[b]) mem_q[idx][b*8 +: 8] <= mem_if.req_data_in[b*8 +: 8];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      outstanding_q <= '0;
      vld_q         <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      vld_q[0]      <= accept;
      pipe_q[0]     <= stage_d;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  resp_fifo #(.WIDTH($bits(resp_t)), .DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (vld_q[LATENCY-1]),
    .din_i   (pipe_q[LATENCY-1]),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .dout_o  (fifo_dout)
  );
  // Credits bound in-flight work to the FIFO depth, so these can only fire on a logic bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    vld_q[LATENCY-1] |-> !fifo_full || pop);
  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
    outstanding_q <= CW'(MAX_OUTSTANDING));
  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    mem_if.resp_valid && !mem_if.resp_ready |=> mem_if.resp_valid && $stable(head));
endmodule

// File: tb/tb_pipelined_memory.sv
// tb_pipelined_memory: directed and randomized checks of pipelined_memory against a word-array model
module tb_pipelined_memory;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0, tests = 0, fails = 0, acc_count = 0;
  typedef struct {
    logic [31:0] data;
    logic        w;
    logic        e;
  } exp_t;
  exp_t     exp_q[$];
  bit [31:0] model_mem [1024];
  pipelined_memory_if #(.ADDRESS_WIDTH(32), .LINE_SIZE(32)) bus ();
  pipelined_memory #(
    .ADDRESS_WIDTH(32), .LINE_SIZE(32), .ENTRIES(1024), .LATENCY(4), .MAX_OUTSTANDING(4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mem_if (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic w,
                      input logic [3:0] s, output int acc_cyc);
    exp_t        x;
    bit          acc = 0;
    int unsigned word;
    bus.req_valid = 1'b1; bus.req_address = a; bus.req_data_in = d;
    bus.req_wen = w; bus.req_strobe = s;
    for (int i = 0; i < 300; i++) begin
      automatic logic rdy = bus.req_ready;
      @(posedge clk); #1;
      if (rdy) begin acc = 1; break; end
    end
    bus.req_valid = 1'b0;
    acc_cyc = cyc;
    if (!acc) begin
      tests++; fails++;
      $display("FAIL send_timeout addr=%h got no accept, required accept", a);
      return;
    end
    acc_count++;
    word = a >> 2;
    x.data = 32'h0; x.w = w; x.e = word >= 1024;
    if (!x.e && w) begin
      for (int b = 0; b < 4; b++) if (s[b]) model_mem[word][b*8 +: 8] = d[b*8 +: 8];
    end else if (!x.e) x.data = model_mem[word];
    exp_q.push_back(x);
  endtask
  task automatic recv(output logic [31:0] d, output logic w, output logic e,
                      output int seen_cyc, output bit ok);
    ok = 0; d = 'x; w = 'x; e = 'x; seen_cyc = -1;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (bus.resp_valid) begin
        d = bus.resp_data_out; w = bus.resp_is_write; e = bus.resp_error;
        seen_cyc = cyc; ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin @(posedge clk); #1; end
    bus.resp_ready = 1'b0;
  endtask
  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({bus.resp_valid, bus.resp_data_out, bus.resp_is_write, bus.resp_error} !== 35'h0) begin
      fails++;
      $display("FAIL reset_hold got v=%b d=%h w=%b e=%b required all 0", bus.resp_valid,
               bus.resp_data_out, bus.resp_is_write, bus.resp_error);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({bus.resp_valid, bus.resp_data_out, bus.resp_is_write, bus.resp_error, bus.req_ready}
        !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_release got v=%b rdy=%b required v=0 rdy=1", bus.resp_valid, bus.req_ready);
    end
  endtask
  task automatic test_write_read;
    logic [31:0] d; logic w, e; int ac, sc; bit ok;
    send(32'h10, 32'hDEADBEEF, 1'b1, 4'hF, ac);
    recv(d, w, e, sc, ok);
    tests++;
    if (!ok || {d, w, e} !== {32'h0, 1'b1, 1'b0}) begin
      fails++; $display("FAIL t1_ack got ok=%0d d=%h w=%b e=%b required d=0 w=1 e=0", ok, d, w, e);
    end
    send(32'h10, 32'h0, 1'b0, 4'h0, ac);
    recv(d, w, e, sc, ok);
    tests++;
    if (!ok || {d, w, e} !== {32'hDEADBEEF, 1'b0, 1'b0}) begin
      fails++; $display("FAIL t1_read got d=%h w=%b e=%b required deadbeef w=0 e=0", d, w, e);
    end
    tests++;
    if (sc - ac !== 4) begin
      fails++; $display("FAIL t1_latency got %0d required 4", sc - ac);
    end
    send(32'h20, 32'hDEADBEEF, 1'b1, 4'hF, ac); recv(d, w, e, sc, ok);
    send(32'h20, 32'h11223344, 1'b1, 4'b0101, ac); recv(d, w, e, sc, ok);
    send(32'h20, 32'h0, 1'b0, 4'h0, ac); recv(d, w, e, sc, ok);
    tests++;
    if (!ok || d !== 32'hDE22BE44) begin
      fails++; $display("FAIL t2_strobe got %h required de22be44", d);
    end
    send(32'h20, 32'hFFFFFFFF, 1'b1, 4'h0, ac); recv(d, w, e, sc, ok);
    tests++;
    if (!ok || {w, e} !== 2'b10) begin
      fails++; $display("FAIL zero_strobe_ack got ok=%0d w=%b e=%b required w=1 e=0", ok, w, e);
    end
    send(32'h20, 32'h0, 1'b0, 4'h0, ac); recv(d, w, e, sc, ok);
    tests++;
    if (!ok || d !== 32'hDE22BE44) begin
      fails++; $display("FAIL zero_strobe_data got %h required de22be44", d);
    end
    exp_q.delete();
  endtask
  task automatic test_backpressure;
    exp_q.delete();
    acc_count = 0;
    bus.resp_ready = 1'b0;
    fork
      for (int i = 0; i < 6; i++) begin
        automatic int ac;
        send(i[0] ? 32'h20 : 32'h10, 32'h0, 1'b0, 4'h0, ac);
      end
      begin
        repeat (10) @(posedge clk);
        #1;
        tests++;
        if (acc_count !== 4 || bus.req_ready !== 1'b0) begin
          fails++; $display("FAIL bp_stall got accepts=%0d rdy=%b required 4 and 0", acc_count, bus.req_ready);
        end
        for (int i = 0; i < 6; i++) begin
          automatic logic [31:0] d; automatic logic w, e; automatic int sc; automatic bit ok;
          automatic exp_t x;
          recv(d, w, e, sc, ok);
          tests++;
          if (!ok || exp_q.size() == 0) begin
            fails++; $display("FAIL bp_resp%0d got ok=%0d queued=%0d required a response", i, ok, exp_q.size());
          end else begin
            x = exp_q.pop_front();
            if ({d, w, e} !== {x.data, x.w, x.e}) begin
              fails++; $display("FAIL bp_resp%0d got %h/%b/%b required %h/%b/%b", i, d, w, e, x.data, x.w, x.e);
            end
          end
        end
      end
    join
    tests++;
    if (acc_count !== 6) begin
      fails++; $display("FAIL bp_total got %0d accepts required 6", acc_count);
    end
  endtask
  task automatic test_raw;
    logic [31:0] d; logic w, e; int a1, a2, sc; bit ok;
    send(32'h40, 32'hA5A5A5A5, 1'b1, 4'hF, a1);
    send(32'h40, 32'h0, 1'b0, 4'h0, a2);
    tests++;
    if (a2 - a1 !== 1) begin
      fails++; $display("FAIL raw_b2b got accept gap %0d required 1", a2 - a1);
    end
    recv(d, w, e, sc, ok);
    recv(d, w, e, sc, ok);
    tests++;
    if (!ok || {d, w, e} !== {32'hA5A5A5A5, 1'b0, 1'b0}) begin
      fails++; $display("FAIL raw_read got %h w=%b e=%b required a5a5a5a5 w=0 e=0", d, w, e);
    end
    exp_q.delete();
  endtask
  task automatic test_out_of_range;
    logic [31:0] d; logic w, e; int ac, sc; bit ok;
    send(32'h0, 32'h12345678, 1'b1, 4'hF, ac); recv(d, w, e, sc, ok);
    send(32'h1000, 32'hCAFEF00D, 1'b1, 4'hF, ac); recv(d, w, e, sc, ok);
    tests++;
    if (!ok || {d, w, e} !== {32'h0, 1'b1, 1'b1}) begin
      fails++; $display("FAIL oor_write got %h w=%b e=%b required 0 w=1 e=1", d, w, e);
    end
    send(32'h1000, 32'h0, 1'b0, 4'h0, ac); recv(d, w, e, sc, ok);
    tests++;
    if (!ok || {d, w, e} !== {32'h0, 1'b0, 1'b1}) begin
      fails++; $display("FAIL oor_read got %h w=%b e=%b required 0 w=0 e=1", d, w, e);
    end
    send(32'h0, 32'h0, 1'b0, 4'h0, ac); recv(d, w, e, sc, ok);
    tests++;
    if (!ok || d !== 32'h12345678) begin
      fails++; $display("FAIL oor_alias got %h required 12345678", d);
    end
    exp_q.delete();
  endtask
  task automatic test_reset_mid;
    logic [31:0] d; logic w, e; int ac, sc; bit ok, saw = 0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h10, 32'h0, 1'b0, 4'h0, ac);
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (bus.resp_valid !== 1'b1) begin
      fails++; $display("FAIL mid_pre got v=%b required 1", bus.resp_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.resp_valid !== 1'b0) begin
      fails++; $display("FAIL mid_async got v=%b required 0", bus.resp_valid);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    tests++;
    if (bus.req_ready !== 1'b1) begin
      fails++; $display("FAIL mid_ready got %b required 1", bus.req_ready);
    end
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.resp_valid) saw = 1;
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b0;
    tests++;
    if (saw) begin
      fails++; $display("FAIL mid_stale got a response required none");
    end
    send(32'h40, 32'h0, 1'b0, 4'h0, ac); recv(d, w, e, sc, ok);
    tests++;
    if (!ok || d !== 32'hA5A5A5A5) begin
      fails++; $display("FAIL mid_persist got %h required a5a5a5a5", d);
    end
    exp_q.delete();
  endtask
  task automatic test_random;
    localparam int TOTAL = 216;
    int got = 0;
    exp_q.delete();
    fork
      for (int i = 0; i < TOTAL; i++) begin
        automatic int          ac;
        automatic int unsigned word;
        for (int g = $urandom_range(0, 2); g > 0; g--) begin @(posedge clk); #1; end
        if (i < 16) send(i << 2, $urandom, 1'b1, 4'hF, ac);
        else begin
          word = ($urandom_range(0, 9) == 0) ? 1024 + $urandom_range(0, 50) : $urandom_range(0, 15);
          send((word << 2) | $urandom_range(0, 3), $urandom, $urandom_range(0, 1) == 1,
               4'($urandom_range(0, 15)), ac);
        end
      end
      for (int i = 0; i < 20000 && got < TOTAL; i++) begin
        automatic logic        rr = $urandom_range(0, 3) != 0;
        automatic bit          stall = 0;
        automatic logic [33:0] hold = '0;
        automatic exp_t        x;
        bus.resp_ready = rr;
        if (bus.resp_valid && rr) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++; $display("FAIL rnd_extra got unexpected response required none");
          end else begin
            x = exp_q.pop_front();
            if ({bus.resp_data_out, bus.resp_is_write, bus.resp_error} !== {x.data, x.w, x.e}) begin
              fails++;
              $display("FAIL rnd_resp%0d got %h/%b/%b required %h/%b/%b", got, bus.resp_data_out,
                       bus.resp_is_write, bus.resp_error, x.data, x.w, x.e);
            end
          end
          got++;
        end else if (bus.resp_valid) begin
          stall = 1;
          hold = {bus.resp_data_out, bus.resp_is_write, bus.resp_error};
        end
        @(posedge clk); #1;
        if (stall) begin
          tests++;
          if (bus.resp_valid !== 1'b1 ||
              {bus.resp_data_out, bus.resp_is_write, bus.resp_error} !== hold) begin
            fails++; $display("FAIL rnd_stall got v=%b %h required v=1 %h", bus.resp_valid,
                              {bus.resp_data_out, bus.resp_is_write, bus.resp_error}, hold);
          end
        end
      end
    join
    bus.resp_ready = 1'b0;
    tests++;
    if (got !== TOTAL) begin
      fails++; $display("FAIL rnd_count got %0d responses required %0d", got, TOTAL);
    end
  endtask
  initial begin
    bus.req_valid = 1'b0; bus.req_address = '0; bus.req_data_in = '0;
    bus.req_wen = 1'b0; bus.req_strobe = '0; bus.resp_ready = 1'b0;
    test_reset;
    test_write_read;
    test_backpressure;
    test_raw;
    test_out_of_range;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
